// File: rtl/fft_twiddle_sched.sv
// fft_twiddle_sched: twiddle BRAM read scheduler for a 2^LOG2N-point radix-2 DIT FFT (Clk/Rst_n, Start/Stall in; Tw_En/Tw_We_A/Tw_We_B/Tw_Addr_A/Tw_Addr_B BRAM drive; Tw_Valid/Stage/Bfly_Idx/Busy/Done status; define TW_SCHED_IFFT_EN to add the Inverse input for conjugate addressing)
module fft_twiddle_sched #(
  parameter int LOG2N = 8,
  parameter int ADDR_W = 8,
  parameter int STG_W = 4
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Start,
  input  logic              Stall,
`ifdef TW_SCHED_IFFT_EN
  input  logic              Inverse,
`endif
  output logic              Tw_En,
  output logic              Tw_We_A,
  output logic              Tw_We_B,
  output logic [ADDR_W-1:0] Tw_Addr_A,
  output logic [ADDR_W-1:0] Tw_Addr_B,
  output logic              Tw_Valid,
  output logic [STG_W-1:0]  Stage,
  output logic [LOG2N-2:0]  Bfly_Idx,
  output logic              Busy,
  output logic              Done
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  logic [1:0] state;
  logic [STG_W-1:0] s;
  logic [LOG2N-3:0] j;
  logic inv;
  logic last;
  logic [LOG2N-2:0] k_a;
  logic [LOG2N-2:0] k_b;
  logic [ADDR_W-1:0] a_a;
  logic [ADDR_W-1:0] a_b;
  function automatic logic [ADDR_W-1:0] idx(input logic [LOG2N-2:0] k, input logic [STG_W-1:0] st);
    logic [ADDR_W-1:0] m;
    m = ADDR_W'(k) & ((ADDR_W'(1) << st) - ADDR_W'(1));
    return m << (STG_W'(LOG2N - 1) - st);
  endfunction
  assign Tw_We_A = 1'b0;
  assign Tw_We_B = 1'b0;
  always_comb begin
    k_a = {j, 1'b0};
    k_b = {j, 1'b1};
    a_a = idx(k_a, s);
    a_b = idx(k_b, s);
    last = (s == STG_W'(LOG2N - 1)) && (&j);
    Tw_En = (state == RUN) && !Stall;
    Tw_Addr_A = inv ? ADDR_W'(0) - a_a : a_a;
    Tw_Addr_B = inv ? ADDR_W'(0) - a_b : a_b;
    Busy = state != IDLE;
    Done = state == DRAIN;
  end
`ifdef TW_SCHED_IFFT_EN
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) inv <= 1'b0;
    else if (state == IDLE && Start) inv <= Inverse;
`else
  assign inv = 1'b0;
`endif
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) begin
      state <= IDLE;
      s <= '0;
      j <= '0;
      Tw_Valid <= 1'b0;
      Stage <= '0;
      Bfly_Idx <= '0;
    end else begin
      Tw_Valid <= Tw_En;
      Stage <= s;
      Bfly_Idx <= k_a;
      if (state == IDLE && Start) begin
        state <= RUN;
        s <= '0;
        j <= '0;
      end else if (state == DRAIN) begin
        state <= IDLE;
      end else if (Tw_En) begin
        state <= last ? DRAIN : RUN;
        j <= j + 1'b1;
        s <= last ? '0 : s + STG_W'(&j);
      end
    end
endmodule

// File: tb/tb_fft_twiddle_sched.sv
// tb_fft_twiddle_sched: randomized and directed self-checking bench for fft_twiddle_sched against a sweep-level reference model
module tb_fft_twiddle_sched;
  localparam int LOG2N = 8;
  localparam int ADDR_W = 8;
  localparam int STG_W = 4;
  localparam int PAIRS = 1 << (LOG2N - 2);
  localparam int ISSUES = PAIRS * LOG2N;
`ifdef TW_SCHED_IFFT_EN
  localparam bit INV_ON = 1'b1;
`else
  localparam bit INV_ON = 1'b0;
`endif
  logic Clk = 1'b0;
  logic Rst_n, Start, Stall, Inverse;
  logic Tw_En, Tw_We_A, Tw_We_B, Tw_Valid, Busy, Done;
  logic [ADDR_W-1:0] Tw_Addr_A, Tw_Addr_B;
  logic [STG_W-1:0] Stage;
  logic [LOG2N-2:0] Bfly_Idx;
  int n_vec = 0;
  int n_bad = 0;
  int m_mode = 0;
  int m_n = 0;
  bit m_inv = 1'b0;
  bit m_pv = 1'b0;
  int m_ps = 0;
  int m_pk = 0;
  int v, d;
  bit g;
  always #5 Clk = ~Clk;
  fft_twiddle_sched #(.LOG2N(LOG2N), .ADDR_W(ADDR_W), .STG_W(STG_W)) dut (
    .Clk(Clk),
    .Rst_n(Rst_n),
    .Start(Start),
    .Stall(Stall),
`ifdef TW_SCHED_IFFT_EN
    .Inverse(Inverse),
`endif
    .Tw_En(Tw_En),
    .Tw_We_A(Tw_We_A),
    .Tw_We_B(Tw_We_B),
    .Tw_Addr_A(Tw_Addr_A),
    .Tw_Addr_B(Tw_Addr_B),
    .Tw_Valid(Tw_Valid),
    .Stage(Stage),
    .Bfly_Idx(Bfly_Idx),
    .Busy(Busy),
    .Done(Done)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, want, $time);
    end
  endtask
  function automatic int ref_addr(input int k, input int st, input bit iv);
    int a;
    a = ((k % (1 << st)) * (1 << (LOG2N - 1 - st))) % (1 << LOG2N);
    return iv ? ((1 << LOG2N) - a) % (1 << LOG2N) : a;
  endfunction
  always @(negedge Clk) begin
    bit e_en;
    if (!Rst_n) begin
      chk("rst_en", Tw_En, 0);
      chk("rst_valid", Tw_Valid, 0);
      chk("rst_done", Done, 0);
      chk("rst_busy", Busy, 0);
      chk("rst_stage", Stage, 0);
      chk("rst_bfly", Bfly_Idx, 0);
      chk("rst_addr_a", Tw_Addr_A, 0);
      chk("rst_addr_b", Tw_Addr_B, 0);
      m_mode = 0;
      m_n = 0;
      m_inv = 1'b0;
      m_pv = 1'b0;
    end else begin
      e_en = (m_mode == 1) && !Stall;
      chk("tw_en", Tw_En, e_en);
      chk("tw_valid", Tw_Valid, m_pv);
      chk("done", Done, m_mode == 2);
      chk("busy", Busy, m_mode != 0);
      chk("we_a", Tw_We_A, 0);
      chk("we_b", Tw_We_B, 0);
      if (m_pv) begin
        chk("stage", Stage, m_ps);
        chk("bfly_idx", Bfly_Idx, m_pk);
      end
      if (m_mode == 1) begin
        chk("addr_a", Tw_Addr_A, ref_addr(2 * (m_n % PAIRS), m_n / PAIRS, m_inv));
        chk("addr_b", Tw_Addr_B, ref_addr(2 * (m_n % PAIRS) + 1, m_n / PAIRS, m_inv));
      end
      m_pv = e_en;
      m_ps = m_n / PAIRS;
      m_pk = 2 * (m_n % PAIRS);
      if (m_mode == 0) begin
        if (Start) begin
          m_mode = 1;
          m_n = 0;
          m_inv = INV_ON && Inverse;
        end
      end else if (m_mode == 1) begin
        if (e_en) begin
          m_n++;
          if (m_n == ISSUES) m_mode = 2;
        end
      end else begin
        m_mode = 0;
      end
    end
  end
  task automatic sweep(input int st_at, input int st_len, input int rs_at, input int rst_at,
                       input bit inv_in, input bit lit, output int vcnt, output int dcyc, output bit gap);
    bit iv;
    iv = INV_ON && inv_in;
    vcnt = 0;
    dcyc = 0;
    gap = 1'b0;
    @(posedge Clk);
    #1;
    Start = 1'b1;
    Inverse = inv_in;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    for (int c = 1; c <= 530; c++) begin
      Stall = (c >= st_at) && (c < st_at + st_len);
      Start = (c == rs_at);
      Inverse = (c > 3) ? 1'($urandom_range(0, 1)) : inv_in;
      if (rst_at > 0 && c == rst_at) Rst_n = 1'b0;
      if (rst_at > 0 && c == rst_at + 2) Rst_n = 1'b1;
      @(negedge Clk);
      if (Tw_Valid) vcnt++;
      if (Done && dcyc == 0) dcyc = c;
      if (dcyc == 0 && !Busy) gap = 1'b1;
      if (st_len > 0 && c >= st_at && c < st_at + st_len) chk("stall_en", Tw_En, 0);
      if (st_len > 0 && c > st_at && c <= st_at + st_len) chk("stall_valid_gap", Tw_Valid, 0);
      if (rst_at > 0 && c == rst_at) begin
        chk("abort_busy", Busy, 0);
        chk("abort_en", Tw_En, 0);
      end
      if (lit) begin
        if (c == 1) begin
          chk("c1_en", Tw_En, 1);
          chk("c1_valid", Tw_Valid, 0);
          chk("c1_addr_b", Tw_Addr_B, 0);
        end
        if (c == 65) begin
          chk("c65_addr_a", Tw_Addr_A, 0);
          chk("c65_addr_b", Tw_Addr_B, iv ? 192 : 64);
        end
        if (c == 449) begin
          chk("c449_addr_a", Tw_Addr_A, 0);
          chk("c449_addr_b", Tw_Addr_B, iv ? 255 : 1);
        end
        if (c == 512) begin
          chk("c512_addr_a", Tw_Addr_A, iv ? 130 : 126);
          chk("c512_addr_b", Tw_Addr_B, iv ? 129 : 127);
        end
        if (c == 513) begin
          chk("c513_valid", Tw_Valid, 1);
          chk("c513_done", Done, 1);
          chk("c513_stage", Stage, 7);
          chk("c513_bfly", Bfly_Idx, 126);
        end
        if (c == 514) begin
          chk("c514_done", Done, 0);
          chk("c514_busy", Busy, 0);
        end
      end
      @(posedge Clk);
      #1;
    end
    Stall = 1'b0;
    Start = 1'b0;
  endtask
  initial begin
    Rst_n = 1'b0;
    Start = 1'b0;
    Stall = 1'b0;
    Inverse = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("reset_busy", Busy, 0);
    chk("reset_valid", Tw_Valid, 0);
    @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    sweep(0, 0, 0, 0, 1'b0, 1'b1, v, d, g);
    chk("plain_valid_count", v, 512);
    chk("plain_done_cycle", d, 513);
    sweep(100, 5, 0, 0, 1'b0, 1'b0, v, d, g);
    chk("stall_valid_count", v, 512);
    chk("stall_done_cycle", d, 518);
    sweep(0, 0, 200, 0, 1'b0, 1'b0, v, d, g);
    chk("restart_done_cycle", d, 513);
    chk("restart_busy_gap", g, 0);
    sweep(0, 0, 0, 300, 1'b0, 1'b0, v, d, g);
    chk("abort_no_done", d, 0);
    sweep(0, 0, 0, 0, 1'b0, 1'b0, v, d, g);
    chk("after_abort_valid_count", v, 512);
    chk("after_abort_done_cycle", d, 513);
    sweep(0, 0, 0, 0, 1'b1, 1'b1, v, d, g);
    chk("inv_valid_count", v, 512);
    chk("inv_done_cycle", d, 513);
    for (int c = 0; c < 4000; c++) begin
      Start = ($urandom_range(0, 60) == 0);
      Stall = ($urandom_range(0, 3) == 0);
      Inverse = 1'($urandom_range(0, 1));
      Rst_n = ($urandom_range(0, 1499) != 0);
      @(posedge Clk);
      #1;
    end
    Rst_n = 1'b1;
    Start = 1'b0;
    Stall = 1'b0;
    repeat (5) @(posedge Clk);
    @(negedge Clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
